// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icode constants, status codes, stage-state enum and icode class helpers
package y86_pkg;
  localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, CMOV = 4'h2, IRMOV = 4'h3;
  localparam logic [3:0] RMMOV = 4'h4, MRMOV = 4'h5, OPQ = 4'h6, JXX = 4'h7;
  localparam logic [3:0] CALL = 4'h8, RET = 4'h9, PUSH = 4'hA, POP = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPDATE, S_HALTED, S_ERROR
  } stage_t;
  function automatic logic usesMem(input logic [3:0] ic);
    return ic inside {RMMOV, MRMOV, CALL, RET, PUSH, POP};
  endfunction
  function automatic logic writesReg(input logic [3:0] ic);
    return ic inside {CMOV, IRMOV, MRMOV, OPQ, CALL, RET, PUSH, POP};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts MEMORY wait cycles; expire fires on the wait that reaches MEM_TIMEOUT (never when 0)
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expire = (MEM_TIMEOUT != 0) && en && (cnt + 1'b1 == TO_W'(MEM_TIMEOUT));
endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multicycle Y86 SEQ stage sequencer with dmem handshake/timeout and stat ownership.
// Define SEQ_PERF_CNT_EN to add the instr_cnt/cycle_cnt performance counter ports.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             dmem_req,
  output logic [3:0]       cur_icode,
  output logic [2:0]       stat,
`ifdef SEQ_PERF_CNT_EN
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`else
  output logic             busy
`endif
);
  if (MEM_TIMEOUT >= 2**TO_W || CNT_W < 1) $error("seq_stage_ctrl: MEM_TIMEOUT must be below 2**TO_W");
  stage_t state, nextState;
  logic [2:0] nextStat;
  logic timeout;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) uTimer (
    .clk(clk), .rst(rst), .clr(!m_en), .en(m_en && !dmem_ack), .expire(timeout)
  );
  always_comb begin
    nextState = state;
    nextStat = stat;
    case (state)
      S_IDLE: nextState = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        nextState = imem_error || icode > POP ? S_ERROR : icode == HALT ? S_HALTED : S_DECODE;
        nextStat = imem_error ? STAT_ADR : icode == HALT ? STAT_HLT : icode > POP ? STAT_INS : stat;
      end
      S_DECODE: nextState = S_EXECUTE;
      S_EXECUTE: nextState = usesMem(cur_icode) ? S_MEMORY : writesReg(cur_icode) ? S_WRITEBACK : S_PCUPDATE;
      S_MEMORY: begin
        // an ack carrying an error beats both completion and the timeout
        if ((dmem_ack && dmem_error) || (!dmem_ack && timeout)) begin
          nextState = S_ERROR;
          nextStat = STAT_ADR;
        end else if (dmem_ack) nextState = writesReg(cur_icode) ? S_WRITEBACK : S_PCUPDATE;
      end
      S_WRITEBACK: nextState = S_PCUPDATE;
      S_PCUPDATE: nextState = S_FETCH;
      default: nextState = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      stat <= STAT_AOK;
      cur_icode <= '0;
    end else begin
      state <= nextState;
      stat <= nextStat;
      if (f_en) cur_icode <= icode;
    end
  end
  assign f_en = state == S_FETCH;
  assign d_en = state == S_DECODE;
  assign e_en = state == S_EXECUTE;
  assign m_en = state == S_MEMORY;
  assign w_en = state == S_WRITEBACK;
  assign pc_en = state == S_PCUPDATE;
  assign dmem_req = m_en;
  assign busy = f_en | d_en | e_en | m_en | w_en | pc_en;
`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (pc_en) instr_cnt <= instr_cnt + CNT_W'(1);
      if (busy) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: directed self-checking bench; expected stage traces are derived per instruction class
module tb_seq_stage_ctrl;
  localparam int F = 0, D = 1, E = 2, M = 3, W = 4, P = 5;
  logic clk = 0, rst = 1, start = 0, imem_error = 0, dmem_ack = 0, dmem_error = 0;
  logic [3:0] icode = 0;
  logic f_en, d_en, e_en, m_en, w_en, pc_en, dmem_req, busy;
  logic [3:0] cur_icode;
  logic [2:0] stat;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif
  seq_stage_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .imem_error(imem_error),
    .dmem_ack(dmem_ack), .dmem_error(dmem_error), .f_en(f_en), .d_en(d_en), .e_en(e_en),
    .m_en(m_en), .w_en(w_en), .pc_en(pc_en), .dmem_req(dmem_req), .cur_icode(cur_icode),
    .stat(stat),
`ifdef SEQ_PERF_CNT_EN
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int reqSeen = 0, wSeen = 0, pcSeen = 0;
  int insAcc = 0, cycAcc = 0, expIns = 0, expCyc = 0;
  logic chkOn = 0, expReq = 0, expBusy = 0;
  logic [5:0] expEn = 0;
  logic [2:0] expStat = 1;
  logic [3:0] expIcode = 0, lastIc = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chkOn) begin
      check("enables", {pc_en, w_en, m_en, e_en, d_en, f_en}, expEn);
      check("dmem_req", dmem_req, expReq);
      check("busy", busy, expBusy);
      check("stat", stat, expStat);
      check("cur_icode", cur_icode, expIcode);
`ifdef SEQ_PERF_CNT_EN
      check("instr_cnt", instr_cnt, expIns);
      check("cycle_cnt", cycle_cnt, expCyc);
`endif
      reqSeen += int'(dmem_req);
      wSeen += int'(w_en);
      pcSeen += int'(pc_en);
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic setIdle(input logic [2:0] st);
    expEn = 0; expReq = 0; expBusy = 0; expStat = st; expIcode = lastIc;
    expIns = insAcc; expCyc = cycAcc;
  endtask
  task automatic doReset;
    chkOn = 0; rst = 1; start = 0; dmem_ack = 0; dmem_error = 0; imem_error = 0; icode = 0;
    step;
    rst = 0; lastIc = 0; insAcc = 0; cycAcc = 0;
    setIdle(1);
    chkOn = 1;
  endtask
  task automatic kick;
    start = 1;
    step;
    start = 0;
  endtask
  // Expected trace: F D E, then M for each memory cycle, W if registers are written, P; terminal outcomes cut it short
  task automatic runInstr(input logic [3:0] ic, input int ackAt, input logic err, input logic imemErr,
                          input int abortAt, output int lat);
    int q[$];
    int mIdx = 0;
    logic [2:0] endStat = 1;
    q.push_back(F);
    if (imemErr) endStat = 3;
    else if (ic == 0) endStat = 2;
    else if (ic > 4'hB) endStat = 4;
    if (endStat == 1) begin
      q.push_back(D);
      q.push_back(E);
      if (ic inside {4, 5, 8, 9, 10, 11}) begin
        if (ackAt < 0) begin
          repeat (15) q.push_back(M);
          endStat = 3;
        end else begin
          repeat (ackAt + 1) q.push_back(M);
          if (err) endStat = 3;
        end
      end
      if (endStat == 1) begin
        if (ic inside {2, 3, 5, 6, 8, 9, 10, 11}) q.push_back(W);
        q.push_back(P);
      end
    end
    lat = q.size();
    foreach (q[i]) begin
      expEn = 6'(1 << q[i]); expReq = q[i] == M; expBusy = 1; expStat = 1;
      expIcode = (i == 0) ? lastIc : ic; expIns = insAcc; expCyc = cycAcc;
      icode = (q[i] == F) ? ic : 4'($urandom);
      imem_error = (q[i] == F) && imemErr;
      dmem_ack = (q[i] == M) && (mIdx == ackAt);
      dmem_error = dmem_ack && err;
      if (i == abortAt) rst = 1;
      step;
      if (q[i] == M) mIdx++;
      cycAcc++;
      if (q[i] == P) insAcc++;
      if (i == abortAt) begin
        rst = 0; dmem_ack = 0; dmem_error = 0; lastIc = 0; insAcc = 0; cycAcc = 0;
        setIdle(1);
        return;
      end
    end
    dmem_ack = 0; dmem_error = 0; imem_error = 0;
    lastIc = ic;
    if (endStat != 1) begin
      repeat (2) begin
        setIdle(endStat);
        step;
      end
    end
  endtask
  initial begin
    int lat, base, wBase, pBase;
    doReset;
    kick;
    for (int k = 0; k < 3; k++) begin
      runInstr(4'h1, 0, 0, 0, -1, lat);
      check("nop_latency", lat, 4);
    end
    check("nop_retired", pcSeen, 3);
`ifdef SEQ_PERF_CNT_EN
    check("instr_cnt_lit", instr_cnt, 3);
    check("cycle_cnt_lit", cycle_cnt, 12);
`endif
    runInstr(4'h3, 0, 0, 0, -1, lat);
    check("irmovq_latency", lat, 5);
    runInstr(4'h6, 0, 0, 0, -1, lat);
    check("opq_latency", lat, 5);
    runInstr(4'h2, 0, 0, 0, -1, lat);
    check("cmov_latency", lat, 5);
    runInstr(4'h7, 0, 0, 0, -1, lat);
    check("jxx_latency", lat, 4);
    base = reqSeen; wBase = wSeen;
    runInstr(4'h5, 2, 0, 0, -1, lat);
    check("mrmovq_latency", lat, 8);
    check("mrmovq_req_cycles", reqSeen - base, 3);
    check("mrmovq_wb", wSeen - wBase, 1);
    wBase = wSeen;
    runInstr(4'h4, 0, 0, 0, -1, lat);
    check("rmmovq_latency", lat, 5);
    check("rmmovq_no_wb", wSeen - wBase, 0);
    runInstr(4'h9, 1, 0, 0, -1, lat);
    check("ret_latency", lat, 7);
    runInstr(4'hB, 0, 0, 0, -1, lat);
    check("pop_latency", lat, 6);
    pBase = pcSeen;
    runInstr(4'hA, 0, 1, 0, -1, lat);
    check("push_err_no_pc", pcSeen - pBase, 0);
    check("push_err_stat", stat, 3);
    doReset;
    kick;
    base = reqSeen;
    runInstr(4'h8, -1, 0, 0, -1, lat);
    check("call_timeout_req", reqSeen - base, 15);
    check("call_timeout_stat", stat, 3);
    doReset;
    kick;
    runInstr(4'h0, 0, 0, 0, -1, lat);
    check("halt_stat", stat, 2);
    doReset;
    kick;
    runInstr(4'hC, 0, 0, 0, -1, lat);
    check("ins_stat", stat, 4);
    doReset;
    kick;
    runInstr(4'h1, 0, 0, 1, -1, lat);
    check("imem_err_stat", stat, 3);
    doReset;
    kick;
    runInstr(4'h5, -1, 0, 0, 4, lat);
    kick;
    runInstr(4'h1, 0, 0, 0, -1, lat);
    runInstr(4'h3, 0, 0, 0, -1, lat);
    chkOn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
